// File: rtl/sme_pkg.sv
// Shared types and helpers for the multi-pattern string-matching engine.
package sme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_LOAD,
    S_T_SCAN,
    S_P_SKIP,
    S_NEXT,
    S_DONE
  } sme_state_e;

  localparam logic [7:0] TERM_DEF = 8'h00;
  localparam logic [7:0] WILD_DEF = 8'h2E;

  // ASCII upper-case letters map to lower case; every other byte passes through.
  function automatic logic [7:0] sme_fold(input logic [7:0] b);
    sme_fold = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction

  function automatic int sme_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sme_window_cmp.sv
// Text sliding window plus length-masked comparator against the loaded pattern.
module sme_window_cmp
  import sme_pkg::*;
#(
  parameter int         PAT_MAX_LEN = 16,
  parameter int         LEN_W       = 5,
  parameter logic [7:0] WILD        = WILD_DEF
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     shift_i,
  input  logic [7:0]               byte_i,
  input  logic [PAT_MAX_LEN*8-1:0] pat_i,
  input  logic [LEN_W-1:0]         len_i,
  input  logic                     fold_i,
  input  logic                     wild_i,
  output logic                     hit_o
);

  localparam int W = PAT_MAX_LEN * 8;

  logic [W-1:0]     win_q, win_d;
  logic [LEN_W-1:0] fill_q;

  function automatic logic byte_ok(input logic [7:0] t, input logic [7:0] p,
                                   input logic fold, input logic wild);
    if (wild && p == WILD) return 1'b1;
    if (fold)              return sme_fold(t) == sme_fold(p);
    return t == p;
  endfunction

  // Slot 0 holds the newest text byte; the pattern buffer uses the same
  // orientation, so slot k of both lines up for the last len bytes.
  always_comb begin
    win_d = {win_q[W-9:0], byte_i};
    hit_o = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_i};
    for (int unsigned k = 0; k < PAT_MAX_LEN; k++) begin
      if (k < 32'(len_i) && !byte_ok(win_d[k*8 +: 8], pat_i[k*8 +: 8], fold_i, wild_i))
        hit_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      win_q  <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      win_q <= win_d;
      if (fill_q != LEN_W'(PAT_MAX_LEN)) fill_q <= fill_q + LEN_W'(1);
    end
  end

endmodule

// File: rtl/sme_multi_pattern.sv
// Multi-pattern string matcher: loads each pattern from the pattern ROM, then
// streams the text ROM once per pattern and reports every match start address.
module sme_multi_pattern
  import sme_pkg::*;
#(
  parameter int         TXT_AW      = 12,
  parameter int         PAT_AW      = 7,
  parameter int         MAX_PAT     = 16,
  parameter int         PAT_MAX_LEN = 16,
  parameter logic [7:0] TERM        = TERM_DEF,
  parameter logic [7:0] WILD        = WILD_DEF,
  localparam int        PNO_W       = sme_clog2(MAX_PAT),
  localparam int        LEN_W       = sme_clog2(PAT_MAX_LEN + 1)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              case_insensitive,
  input  logic              wildcard_en,
  output logic [TXT_AW-1:0] T_addr,
  input  logic [7:0]        T_data,
  output logic [PAT_AW-1:0] P_addr,
  input  logic [7:0]        P_data,
  output logic [PNO_W-1:0]  pattern_no,
  output logic [TXT_AW-1:0] match_addr,
  output logic              valid,
  output logic              overflow,
  output logic              finish
);

  sme_state_e                 state_q, state_d;
  logic                       ci_q, ci_d, wc_q, wc_d;
  logic [PAT_AW-1:0]          p_addr_q, p_addr_d;
  logic [TXT_AW-1:0]          t_addr_q, t_addr_d, rd_addr_q, rd_addr_d;
  logic                       issued_q, issued_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [PAT_MAX_LEN*8-1:0]   pbuf_q, pbuf_d;
  logic [PNO_W-1:0]           pno_q, pno_d;
  logic [TXT_AW-1:0]          maddr_q, maddr_d;
  logic                       valid_q, valid_d, ovf_q, ovf_d, fin_q, fin_d;
  logic                       shift, hit;

  sme_window_cmp #(
    .PAT_MAX_LEN (PAT_MAX_LEN),
    .LEN_W       (LEN_W),
    .WILD        (WILD)
  ) u_win (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_q != S_T_SCAN),
    .shift_i (shift),
    .byte_i  (T_data),
    .pat_i   (pbuf_q),
    .len_i   (len_q),
    .fold_i  (ci_q),
    .wild_i  (wc_q),
    .hit_o   (hit)
  );

  // The pattern address always runs one ahead of the byte being consumed and
  // parks on the byte after TERM, so P_LOAD sees valid data on its first cycle.
  always_comb begin
    state_d   = state_q;
    ci_d      = ci_q;
    wc_d      = wc_q;
    p_addr_d  = p_addr_q;
    t_addr_d  = t_addr_q;
    rd_addr_d = rd_addr_q;
    issued_d  = issued_q;
    len_d     = len_q;
    pbuf_d    = pbuf_q;
    pno_d     = pno_q;
    maddr_d   = maddr_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    fin_d     = fin_q;
    shift     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ci_d     = case_insensitive;
        wc_d     = wildcard_en;
        p_addr_d = p_addr_q + PAT_AW'(1);
        len_d    = '0;
        state_d  = S_P_LOAD;
      end
      S_P_LOAD: begin
        if (P_data == TERM) begin
          if (len_q == '0) begin
            state_d = S_DONE;
            fin_d   = 1'b1;
          end else begin
            state_d  = S_T_SCAN;
            t_addr_d = '0;
            issued_d = 1'b0;
          end
        end else if (len_q == LEN_W'(PAT_MAX_LEN)) begin
          ovf_d    = 1'b1;
          p_addr_d = p_addr_q + PAT_AW'(1);
          state_d  = S_P_SKIP;
        end else begin
          pbuf_d   = {pbuf_q[(PAT_MAX_LEN-1)*8-1:0], P_data};
          len_d    = len_q + LEN_W'(1);
          p_addr_d = p_addr_q + PAT_AW'(1);
        end
      end
      S_T_SCAN: begin
        if (!issued_q) begin
          rd_addr_d = t_addr_q;
          t_addr_d  = t_addr_q + TXT_AW'(1);
          issued_d  = 1'b1;
        end else if (T_data == TERM) begin
          state_d = S_NEXT;
        end else begin
          shift = 1'b1;
          if (hit) begin
            valid_d = 1'b1;
            maddr_d = rd_addr_q - TXT_AW'(len_q) + TXT_AW'(1);
          end
          if (rd_addr_q == '1) begin
            state_d = S_NEXT;
          end else begin
            rd_addr_d = t_addr_q;
            t_addr_d  = t_addr_q + TXT_AW'(1);
          end
        end
      end
      S_P_SKIP: begin
        if (P_data == TERM) state_d = S_NEXT;
        else                p_addr_d = p_addr_q + PAT_AW'(1);
      end
      S_NEXT: begin
        if (pno_q == PNO_W'(MAX_PAT - 1)) begin
          state_d = S_DONE;
          fin_d   = 1'b1;
        end else begin
          pno_d    = pno_q + PNO_W'(1);
          p_addr_d = p_addr_q + PAT_AW'(1);
          len_d    = '0;
          state_d  = S_P_LOAD;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ci_q      <= 1'b0;
      wc_q      <= 1'b0;
      p_addr_q  <= '0;
      t_addr_q  <= '0;
      rd_addr_q <= '0;
      issued_q  <= 1'b0;
      len_q     <= '0;
      pbuf_q    <= '0;
      pno_q     <= '0;
      maddr_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ci_q      <= ci_d;
      wc_q      <= wc_d;
      p_addr_q  <= p_addr_d;
      t_addr_q  <= t_addr_d;
      rd_addr_q <= rd_addr_d;
      issued_q  <= issued_d;
      len_q     <= len_d;
      pbuf_q    <= pbuf_d;
      pno_q     <= pno_d;
      maddr_q   <= maddr_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      fin_q     <= fin_d;
    end
  end

  assign T_addr     = t_addr_q;
  assign P_addr     = p_addr_q;
  assign pattern_no = pno_q;
  assign match_addr = maddr_q;
  assign valid      = valid_q;
  assign overflow   = ovf_q;
  assign finish     = fin_q;

endmodule

// File: tb/tb_sme_multi_pattern.sv
// Bench for sme_multi_pattern: directed vector table, reset-during-scan sequence
// and randomized runs checked against a substring-search reference model.
module tb_sme_multi_pattern;

  localparam int TXT_AW  = 5;
  localparam int PAT_AW  = 7;
  localparam int MAX_PAT = 4;
  localparam int PML     = 5;
  localparam int PNO_W   = 2;
  localparam int TDEPTH  = 1 << TXT_AW;
  localparam int PDEPTH  = 1 << PAT_AW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ci = 1'b0;
  logic              wc = 1'b0;
  logic [TXT_AW-1:0] T_addr;
  logic [7:0]        T_data;
  logic [PAT_AW-1:0] P_addr;
  logic [7:0]        P_data;
  logic [PNO_W-1:0]  pattern_no;
  logic [TXT_AW-1:0] match_addr;
  logic              valid, overflow, finish;

  logic [7:0] trom [TDEPTH];
  logic [7:0] prom [PDEPTH];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    T_data <= trom[T_addr];
    P_data <= prom[P_addr];
  end

  sme_multi_pattern #(
    .TXT_AW      (TXT_AW),
    .PAT_AW      (PAT_AW),
    .MAX_PAT     (MAX_PAT),
    .PAT_MAX_LEN (PML)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .case_insensitive (ci),
    .wildcard_en      (wc),
    .T_addr           (T_addr),
    .T_data           (T_data),
    .P_addr           (P_addr),
    .P_data           (P_data),
    .pattern_no       (pattern_no),
    .match_addr       (match_addr),
    .valid            (valid),
    .overflow         (overflow),
    .finish           (finish)
  );

  typedef struct {
    string txt;
    string pats;
    bit    ci;
    bit    wc;
    string exp;
    bit    ovf;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input bit ok, input string act, input string req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got '%s', expected '%s'", name, act, req);
  endtask

  // '|' in the pattern string stands for the TERM byte between patterns.
  task automatic load(input string txt, input string pats);
    for (int i = 0; i < TDEPTH; i++) trom[i] = 8'h00;
    for (int i = 0; i < txt.len() && i < TDEPTH; i++) trom[i] = txt[i];
    for (int i = 0; i < PDEPTH; i++) prom[i] = 8'h00;
    for (int i = 0; i < pats.len(); i++) prom[i] = (pats[i] == 8'h7C) ? 8'h00 : pats[i];
  endtask

  task automatic start(input bit c, input bit w);
    @(negedge clk);
    reset = 1'b1;
    ci = c;
    wc = w;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic byte unsigned lc(input byte unsigned x, input bit c);
    return (c && x >= 65 && x <= 90) ? x + 8'd32 : x;
  endfunction

  function automatic string model(input string txt, input string pats,
                                  input bit c, input bit w, output bit ovf);
    byte unsigned t[$];
    byte unsigned pb[$];
    byte unsigned p[$];
    string r;
    int pos;
    bit ok;
    r = "";
    pos = 0;
    ovf = 1'b0;
    for (int i = 0; i < txt.len() && t.size() < TDEPTH; i++) t.push_back(txt[i]);
    for (int i = 0; i < pats.len(); i++) pb.push_back(pats[i] == 8'h7C ? 8'h00 : pats[i]);
    pb.push_back(8'h00);
    pb.push_back(8'h00);
    for (int pn = 0; pn < MAX_PAT; pn++) begin
      p.delete();
      while (pb[pos] != 8'h00) begin
        p.push_back(pb[pos]);
        pos++;
      end
      pos++;
      if (p.size() == 0) break;
      if (p.size() > PML) begin
        ovf = 1'b1;
        continue;
      end
      for (int s = 0; s + p.size() <= t.size(); s++) begin
        ok = 1'b1;
        for (int k = 0; k < p.size(); k++)
          if (!(w && p[k] == 8'h2E) && lc(p[k], c) != lc(t[s+k], c)) ok = 1'b0;
        if (ok) r = {r, $sformatf("%0d,%0d;", pn, s)};
      end
    end
    return r;
  endfunction

  task automatic run_check(input string name, input string exp, input bit exp_ovf);
    string got;
    int    clash;
    bit    done;
    got = "";
    clash = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (valid) got = {got, $sformatf("%0d,%0d;", pattern_no, match_addr)};
      if (valid && finish) clash++;
      if (finish) done = 1'b1;
    end
    chk({name, " finish"}, done, $sformatf("%0b", done), "1 within 3000 cycles");
    chk({name, " valid+finish"}, clash == 0, $sformatf("%0d", clash), "0");
    chk({name, " matches"}, got == exp, got, exp);
    chk({name, " overflow"}, overflow == exp_ovf, $sformatf("%0b", overflow), $sformatf("%0b", exp_ovf));
    if (done) begin
      repeat (3) @(negedge clk);
      chk({name, " finish held"}, finish && !valid,
          $sformatf("finish=%0b valid=%0b", finish, valid), "finish=1 valid=0");
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " valid"},      valid == 1'b0,      $sformatf("%0b", valid),      "0");
    chk({name, " finish"},     finish == 1'b0,     $sformatf("%0b", finish),     "0");
    chk({name, " overflow"},   overflow == 1'b0,   $sformatf("%0b", overflow),   "0");
    chk({name, " pattern_no"}, pattern_no == '0,   $sformatf("%0d", pattern_no), "0");
    chk({name, " match_addr"}, match_addr == '0,   $sformatf("%0d", match_addr), "0");
    chk({name, " T_addr"},     T_addr == '0,       $sformatf("%0d", T_addr),     "0");
    chk({name, " P_addr"},     P_addr == '0,       $sformatf("%0d", P_addr),     "0");
  endtask

  initial begin
    string txt, pats, exp, alpha_t, alpha_p;
    bit    e_ovf, found, rc, rw;

    vecs[0]  = '{"abcabc", "bc", 1'b0, 1'b0, "0,1;0,4;", 1'b0};
    vecs[1]  = '{"ABab", "ab", 1'b1, 1'b0, "0,0;0,2;", 1'b0};
    vecs[2]  = '{"ABab", "ab", 1'b0, 1'b0, "0,2;", 1'b0};
    vecs[3]  = '{"abcaXc", "a.c", 1'b0, 1'b1, "0,0;0,3;", 1'b0};
    vecs[4]  = '{"abcaXc", "a.c", 1'b0, 1'b0, "", 1'b0};
    vecs[5]  = '{"aaaa", "aa|aaaaa", 1'b0, 1'b0, "0,0;0,1;0,2;", 1'b0};
    vecs[6]  = '{"xab", "abcdef|ab", 1'b0, 1'b0, "1,1;", 1'b1};
    vecs[7]  = '{"ab", "a|b|ab|x|b", 1'b0, 1'b0, "0,0;1,1;2,0;", 1'b0};
    vecs[8]  = '{"zabcde", "abcde", 1'b0, 1'b0, "0,1;", 1'b0};
    vecs[9]  = '{"xAyB", ".b", 1'b1, 1'b1, "0,2;", 1'b0};
    vecs[10] = '{"ab", "b.", 1'b0, 1'b1, "", 1'b0};
    vecs[11] = '{"qqqqqqqqqqqqqqqqqqqqqqqqqqqqqqxy", "xy|qx", 1'b0, 1'b0, "0,30;1,29;", 1'b0};
    vecs[12] = '{"Z[A@", "z|{|a", 1'b1, 1'b0, "0,0;2,2;", 1'b0};
    vecs[13] = '{"abc", "", 1'b0, 1'b0, "", 1'b0};

    load("abc", "a");
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    foreach (vecs[i]) begin
      load(vecs[i].txt, vecs[i].pats);
      start(vecs[i].ci, vecs[i].wc);
      run_check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].ovf);
    end

    // Reset while pattern 2 is scanning, then rerun with a different mode.
    load("abCabcAb", "ab|bc|ca|c");
    start(1'b0, 1'b0);
    found = 1'b0;
    for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
      @(negedge clk);
      if (pattern_no == 2'd2 && T_addr == 5'd3) found = 1'b1;
    end
    chk("midreset reach scan", found, $sformatf("%0b", found), "1");
    reset = 1'b1;
    ci = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    reset = 1'b0;
    exp = model("abCabcAb", "ab|bc|ca|c", 1'b1, 1'b0, e_ovf);
    run_check("midreset rerun", exp, e_ovf);

    alpha_t = "abAB.";
    alpha_p = "abA.";
    for (int r = 0; r < 25; r++) begin
      txt = "";
      pats = "";
      for (int i = 0; i < int'($urandom_range(1, 40)); i++)
        txt = $sformatf("%s%c", txt, alpha_t[$urandom_range(0, 4)]);
      for (int n = 0; n < int'($urandom_range(1, 5)); n++) begin
        if (n > 0) pats = {pats, "|"};
        for (int i = 0; i < int'($urandom_range(1, 6)); i++)
          pats = $sformatf("%s%c", pats, alpha_p[$urandom_range(0, 3)]);
      end
      rc = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      exp = model(txt, pats, rc, rw, e_ovf);
      load(txt, pats);
      start(rc, rw);
      run_check($sformatf("rand%0d", r), exp, e_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sme_multi_pattern.md
Name: sme_multi_pattern

Overview:
Parametrised string-matching engine, next generation of the single-configuration SME. Streams a text ROM once per pattern and reports every start address where each stored pattern matches. Adds configurable text/pattern depths, max pattern length, pattern count, a wildcard mode and an overflow flag. Sits between the text/pattern ROMs (1-cycle-latency synchronous read) and the result collector/testbench.

Parameters:
TXT_AW, 12, text ROM address width (depth 2**TXT_AW)
PAT_AW, 7, pattern ROM address width
MAX_PAT, 16, max patterns processed; pattern_no width PNO_W = clog2(MAX_PAT)
PAT_MAX_LEN, 16, max pattern length (window size)
TERM, 8'h00, terminator byte for text and pattern
WILD, 8'h2E, wildcard byte ('.')

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
case_insensitive  in  1  fold A-Z to a-z on both sides; sampled when reset is released
wildcard_en  in  1  WILD in pattern matches any text byte; sampled with case_insensitive
T_addr  out  TXT_AW  text ROM address
T_data  in  8  text ROM data, valid one cycle after T_addr
P_addr  out  PAT_AW  pattern ROM address
P_data  in  8  pattern ROM data, valid one cycle after P_addr
pattern_no  out  PNO_W  index of matched pattern
match_addr  out  TXT_AW  start address of match
valid  out  1  one-cycle pulse qualifying pattern_no/match_addr
overflow  out  1  sticky: some pattern exceeded PAT_MAX_LEN
finish  out  1  level, all patterns done; held until reset

Behaviour:
- Reset values: T_addr=0, P_addr=0, pattern_no=0, match_addr=0, valid=0, overflow=0, finish=0; FSM=IDLE; mode bits latched on the first cycle reset is low.
- Pattern ROM format: patterns packed back-to-back, each ended by TERM; an empty pattern (TERM immediately) or MAX_PAT patterns completed ends the list.
- Text ends at first TERM or at address 2**TXT_AW-1 (inclusive), whichever first.
- FSM: IDLE -> P_LOAD -> (T_SCAN | P_SKIP | DONE); T_SCAN -> NEXT; P_SKIP -> NEXT; NEXT -> P_LOAD | DONE.
- IDLE: one cycle, latch modes, issue P_addr.
- P_LOAD: read pattern bytes into register buffer, count len. TERM at len 0 -> DONE. Length > PAT_MAX_LEN -> set overflow, go P_SKIP (consume to TERM), pattern produces no matches but consumes its index.
- T_SCAN: issue T_addr 0,1,2... one per cycle; each returned byte shifted into a PAT_MAX_LEN window; when >= len bytes captured, compare last len bytes to pattern (fold/wildcard per latched mode). Hit -> next cycle valid=1, match_addr = addr_of_last_byte - len + 1, pattern_no = current index.
- Overlapping matches all reported; order: pattern ascending, then address ascending.
- Pattern longer than text: no matches, no error.
- TERM text byte never enters window; wildcard never matches beyond text end.
- Folding: byte in 0x41..0x5A gets bit5 set; other bytes unchanged.
- NEXT: pattern_no increments (wraps not possible: MAX_PAT limit ends list), P_addr continues after TERM.
- DONE: finish=1 in the cycle after the last valid; valid and finish never high together; FSM stays until reset.
- Reset mid-operation: next cycle all outputs at reset values, restart from pattern 0 with newly sampled modes.
- Throughput: one text byte per cycle; per-pattern overhead <= len+4 cycles.

Decomposition:
- Package sme_pkg: FSM state enum, TERM/WILD defaults, fold function, clog2 helper.
- Sub-module sme_window_cmp: shift window + len-masked comparator with fold/wildcard; produces hit.

Test Plan:
- Text "abcabc",TERM; pattern "bc",TERM,TERM -> valid (0,1),(0,4); then finish, overflow=0.
- Text "ABab"; pattern "ab": case_insensitive=1 -> (0,0),(0,2); case_insensitive=0 -> (0,2) only.
- Text "abcaXc"; pattern "a.c": wildcard_en=1 -> (0,0),(0,3); wildcard_en=0 -> none, finish.
- Text "aaaa"; patterns "aa","aaaaa" -> (0,0),(0,1),(0,2); pattern 1 none; finish.
- PAT_MAX_LEN=4; patterns "abcdef","ab" over text "xab" -> overflow=1, (1,1) only.
- Reset asserted during T_SCAN of pattern 2 -> valid/finish low next cycle; rerun reproduces full match list from pattern 0.
